// File: rtl/wb_sel_unit.sv
// Writeback select unit: picks ALU / PC+4 / load data for the RF write port and
// handles the data-RAM load handshake with sub-word extension, stall and timeout.
//
// state  | meaning
// S_IDLE | accepting instructions; ALU/PC4 writes and zero-wait loads retire here
// S_WAIT | load outstanding, stall asserted, waiting for dram_rvalid or timeout
module wb_sel_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_valid,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_rf_we_req,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_alu_c,
  input  logic [31:0] i_pc4,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_dram_rvalid,
  input  logic [31:0] i_dram_rdata,
  output logic        o_stall,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_wR,
  output logic [31:0] o_rf_wD,
  output logic        o_ld_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state;
  logic [4:0]    r_rd;
  logic          r_we_req;
  logic [2:0]    r_ld_type;
  logic [1:0]    r_addr_lo;
  logic [CW-1:0] r_cnt;

  logic [2:0]    w_type;
  logic [1:0]    w_addr;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;

  // A zero-wait load extends from the live inputs; a waited load from the latched copy.
  always_comb begin
    w_type = (r_state == S_WAIT) ? r_ld_type : i_ld_type;
    w_addr = (r_state == S_WAIT) ? r_addr_lo : i_ld_addr_lo;
    w_byte = 8'h00;
    case (w_addr)
      2'd0: w_byte = i_dram_rdata[7:0];
      2'd1: w_byte = i_dram_rdata[15:8];
      2'd2: w_byte = i_dram_rdata[23:16];
      2'd3: w_byte = i_dram_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = w_addr[1] ? i_dram_rdata[31:16] : i_dram_rdata[15:0];
    case (w_type)
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = {16'h0000, w_half};
      3'b011:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h000000, w_byte};
      default: w_ext = i_dram_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rd      <= 5'd0;
      r_we_req  <= 1'b0;
      r_ld_type <= 3'd0;
      r_addr_lo <= 2'd0;
      r_cnt     <= '0;
      o_stall   <= 1'b0;
      o_rf_we   <= 1'b0;
      o_rf_wR   <= 5'd0;
      o_rf_wD   <= 32'd0;
      o_ld_err  <= 1'b0;
    end else begin
      o_rf_we  <= 1'b0;
      o_ld_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_wb_valid) begin
            case (i_wb_sel)
              SEL_ALU, SEL_PC4: begin
                o_rf_we <= i_rf_we_req & (i_rd != 5'd0);
                o_rf_wR <= i_rd;
                o_rf_wD <= (i_wb_sel == SEL_PC4) ? i_pc4 : i_alu_c;
              end
              SEL_LOAD: begin
                if (i_dram_rvalid) begin
                  o_rf_we <= i_rf_we_req & (i_rd != 5'd0);
                  o_rf_wR <= i_rd;
                  o_rf_wD <= w_ext;
                end else begin
                  r_rd      <= i_rd;
                  r_we_req  <= i_rf_we_req;
                  r_ld_type <= i_ld_type;
                  r_addr_lo <= i_ld_addr_lo;
                  r_cnt     <= '0;
                  r_state   <= S_WAIT;
                  o_stall   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_WAIT: begin
          if (i_dram_rvalid) begin
            o_rf_we <= r_we_req & (r_rd != 5'd0);
            o_rf_wR <= r_rd;
            o_rf_wD <= w_ext;
            r_state <= S_IDLE;
            o_stall <= 1'b0;
          end else if (r_cnt == TC) begin
            o_ld_err <= 1'b1;
            r_state  <= S_IDLE;
            o_stall  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sel_unit.sv
// Directed bench for wb_sel_unit: ALU/PC4 writes, waited and zero-wait loads,
// sub-word extension, timeout abort and reset during an outstanding load.
module tb_wb_sel_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [1:0]  wb_sel;
  logic        rf_we_req;
  logic [4:0]  rd;
  logic [31:0] alu_c;
  logic [31:0] pc4;
  logic [2:0]  ld_type;
  logic [1:0]  ld_addr_lo;
  logic        dram_rvalid;
  logic [31:0] dram_rdata;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;
  logic        ld_err;

  int n_chk  = 0;
  int n_fail = 0;

  wb_sel_unit #(.TIMEOUT(4)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wb_valid   (wb_valid),
    .i_wb_sel     (wb_sel),
    .i_rf_we_req  (rf_we_req),
    .i_rd         (rd),
    .i_alu_c      (alu_c),
    .i_pc4        (pc4),
    .i_ld_type    (ld_type),
    .i_ld_addr_lo (ld_addr_lo),
    .i_dram_rvalid(dram_rvalid),
    .i_dram_rdata (dram_rdata),
    .o_stall      (stall),
    .o_rf_we      (rf_we),
    .o_rf_wR      (rf_wR),
    .o_rf_wD      (rf_wD),
    .o_ld_err     (ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // zero-wait extension vectors: ld_type, addr_lo, rdata, expected word
  typedef struct {
    logic [2:0]  t;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } ext_vec_t;

  ext_vec_t ev[6];

  initial begin
    ev[0] = '{3'b010, 2'b10, 32'h8001_AAAA, 32'h0000_8001};
    ev[1] = '{3'b001, 2'b10, 32'h8001_AAAA, 32'hFFFF_8001};
    ev[2] = '{3'b100, 2'b01, 32'h1234_56F0, 32'h0000_0056};
    ev[3] = '{3'b011, 2'b00, 32'h1234_56F0, 32'hFFFF_FFF0};
    ev[4] = '{3'b001, 2'b01, 32'h1234_9ABC, 32'hFFFF_9ABC};
    ev[5] = '{3'b111, 2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    rst = 1'b1; wb_valid = 1'b0; wb_sel = 2'b11; rf_we_req = 1'b0; rd = 5'd0;
    alu_c = 32'd0; pc4 = 32'd0; ld_type = 3'd0; ld_addr_lo = 2'd0;
    dram_rvalid = 1'b0; dram_rdata = 32'd0;
    step(); step();
    chk("rst_stall", stall, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_wR", rf_wR, 0);
    chk("rst_wD", rf_wD, 0);
    chk("rst_err", ld_err, 0);
    rst = 1'b0;

    // ALU write
    wb_valid = 1'b1; wb_sel = 2'b00; rf_we_req = 1'b1; rd = 5'd5; alu_c = 32'h1234_5678;
    step();
    chk("alu_we", rf_we, 1);
    chk("alu_wR", rf_wR, 5);
    chk("alu_wD", rf_wD, 32'h1234_5678);
    chk("alu_stall", stall, 0);
    wb_valid = 1'b0;
    step();
    chk("alu_we_pulse", rf_we, 0);

    // PC4 write, then rd=0 suppression
    wb_valid = 1'b1; wb_sel = 2'b10; rd = 5'd1; pc4 = 32'h1C00_0010;
    step();
    chk("pc4_we", rf_we, 1);
    chk("pc4_wD", rf_wD, 32'h1C00_0010);
    wb_sel = 2'b00; rd = 5'd0; alu_c = 32'hFFFF_FFFF;
    step();
    chk("rd0_we", rf_we, 0);
    wb_sel = 2'b11; rd = 5'd4;
    step();
    chk("none_we", rf_we, 0);
    wb_valid = 1'b0;

    // waited ld.b; inputs scrambled during stall must not matter
    wb_valid = 1'b1; wb_sel = 2'b01; rd = 5'd7; ld_type = 3'b011; ld_addr_lo = 2'b11;
    step();
    chk("ldb_stall0", stall, 1);
    wb_valid = 1'b0; rd = 5'd2; ld_type = 3'b000; ld_addr_lo = 2'b00; rf_we_req = 1'b0;
    step();
    chk("ldb_stall1", stall, 1);
    step();
    chk("ldb_stall2", stall, 1);
    chk("ldb_we_wait", rf_we, 0);
    dram_rvalid = 1'b1; dram_rdata = 32'h80FF_0000;
    step();
    chk("ldb_we", rf_we, 1);
    chk("ldb_wR", rf_wR, 7);
    chk("ldb_wD", rf_wD, 32'hFFFF_FF80);
    chk("ldb_stall_done", stall, 0);
    dram_rvalid = 1'b0;
    step();
    chk("ldb_we_pulse", rf_we, 0);

    // zero-wait loads across widths
    rf_we_req = 1'b1; rd = 5'd3; wb_valid = 1'b1; wb_sel = 2'b01; dram_rvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_type = ev[i].t; ld_addr_lo = ev[i].a; dram_rdata = ev[i].d;
      step();
      chk($sformatf("zw%0d_stall", i), stall, 0);
      chk($sformatf("zw%0d_we", i), rf_we, 1);
      chk($sformatf("zw%0d_wD", i), rf_wD, ev[i].e);
    end
    wb_valid = 1'b0; dram_rvalid = 1'b0;
    step();
    chk("zw_we_pulse", rf_we, 0);

    // timeout: 4 stall cycles then ld_err, late rvalid ignored
    wb_valid = 1'b1; wb_sel = 2'b01; rd = 5'd9; ld_type = 3'b000;
    step();
    chk("to_stall0", stall, 1);
    wb_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("to_stall%0d", i), stall, 1);
      chk($sformatf("to_err%0d", i), ld_err, 0);
    end
    step();
    chk("to_err", ld_err, 1);
    chk("to_stall_off", stall, 0);
    chk("to_we", rf_we, 0);
    dram_rvalid = 1'b1; dram_rdata = 32'h5555_5555;
    step();
    chk("to_err_pulse", ld_err, 0);
    chk("late_rv_we", rf_we, 0);
    chk("late_rv_stall", stall, 0);
    dram_rvalid = 1'b0;

    // reset during WAIT aborts the load
    wb_valid = 1'b1; wb_sel = 2'b01; rd = 5'd11;
    step();
    chk("rw_stall", stall, 1);
    wb_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; dram_rvalid = 1'b1; dram_rdata = 32'hCAFE_F00D;
    step();
    chk("rw_we", rf_we, 0);
    chk("rw_stall_off", stall, 0);
    chk("rw_wR", rf_wR, 0);
    chk("rw_wD", rf_wD, 0);
    chk("rw_err", ld_err, 0);
    dram_rvalid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
